// File: rtl/led_seq_ctrl.sv
// LED select sequencer: debounced manual load of a 3-bit key code,
// or timed auto stepping (wrap or ping-pong) feeding an active-low 3-to-8 decoder.
module led_seq_ctrl #(
    parameter int TICK_DIV  = 5000000,
    parameter int DB_CYCLES = 1000000,
    parameter int DIV_W     = 24,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] keyin,
    input  logic       key_load,
    input  logic       run,
    input  logic       pingpong,
    output logic [2:0] sel,
    output logic [7:0] led,
    output logic       step
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);

    logic [2:0]       r_key_s1;
    logic [2:0]       r_key_s2;
    logic             r_ld_s1;
    logic             r_ld_s2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_db;
    logic             r_db_q;
    logic [DIV_W-1:0] r_tick_cnt;
    state_t           r_state;
    logic [2:0]       r_sel;
    logic [7:0]       r_led;
    logic             r_step;

    state_t           w_state_nxt;
    logic [2:0]       w_sel_nxt;
    logic [DIV_W-1:0] w_tick_nxt;
    logic             w_step;
    logic             w_press;
    logic             w_tick;
    logic             w_adv;

    assign w_press = r_db & ~r_db_q;
    assign w_tick  = (r_state != IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_adv   = w_tick & run & ~w_press;

    // Synchronizers and pushbutton debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1 <= 3'd0;
            r_key_s2 <= 3'd0;
            r_ld_s1  <= 1'b0;
            r_ld_s2  <= 1'b0;
            r_db_cnt <= '0;
            r_db     <= 1'b0;
            r_db_q   <= 1'b0;
        end else begin
            r_key_s1 <= keyin;
            r_key_s2 <= r_key_s1;
            r_ld_s1  <= key_load;
            r_ld_s2  <= r_ld_s1;
            r_db_q   <= r_db;
            if (r_ld_s2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db     <= r_ld_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (run) w_state_nxt = RUN_UP;
            end
            RUN_UP: begin
                if (!run)
                    w_state_nxt = IDLE;
                else if (w_adv && pingpong && r_sel == 3'd7)
                    w_state_nxt = RUN_DOWN;
            end
            RUN_DOWN: begin
                if (!run)
                    w_state_nxt = IDLE;
                else if (w_adv && pingpong && r_sel == 3'd0)
                    w_state_nxt = RUN_UP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A load outranks a coincident tick and restarts the period
    always_comb begin
        w_sel_nxt  = r_sel;
        w_tick_nxt = r_tick_cnt;
        w_step     = 1'b0;
        if (w_press) begin
            w_sel_nxt  = r_key_s2;
            w_tick_nxt = '0;
            w_step     = 1'b1;
        end else if (r_state == IDLE || !run) begin
            w_tick_nxt = '0;
        end else if (w_tick) begin
            w_tick_nxt = '0;
            w_step     = 1'b1;
            if (pingpong && r_state == RUN_UP && r_sel == 3'd7)
                w_sel_nxt = 3'd6;
            else if (pingpong && r_state == RUN_DOWN && r_sel == 3'd0)
                w_sel_nxt = 3'd1;
            else if (r_state == RUN_UP)
                w_sel_nxt = r_sel + 3'd1;
            else
                w_sel_nxt = r_sel - 3'd1;
        end else begin
            w_tick_nxt = r_tick_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_sel      <= 3'd0;
            r_led      <= 8'hFE;
            r_step     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_nxt;
            r_sel      <= w_sel_nxt;
            r_led      <= ~(8'd1 << w_sel_nxt);
            r_step     <= w_step;
        end
    end

    assign sel  = r_sel;
    assign led  = r_led;
    assign step = r_step;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized scoreboard bench for led_seq_ctrl against an event-level
// reference model (synchronizer delay queue, stable-history debounce, period counter).
module tb_led_seq_ctrl;

    localparam int TD = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] keyin;
    logic       key_load;
    logic       run;
    logic       pingpong;
    logic [2:0] sel;
    logic [7:0] led;
    logic       step;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .TICK_DIV (TD),
        .DB_CYCLES(DB),
        .DIV_W    (4),
        .DB_W     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keyin   (keyin),
        .key_load(key_load),
        .run     (run),
        .pingpong(pingpong),
        .sel     (sel),
        .led     (led),
        .step    (step)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [2:0] exp_q[$];

    logic [2:0] m_sel;
    int         m_dir;
    int         m_period;
    bit         m_running;
    bit         m_db;
    bit         m_press;
    bit         ld_pipe[$];
    logic [2:0] kv_pipe[$];
    bit         s2_hist[$];

    task automatic model_reset();
        m_sel     = 3'd0;
        m_dir     = 1;
        m_period  = 0;
        m_running = 1'b0;
        m_db      = 1'b0;
        m_press   = 1'b0;
        exp_q.delete();
        ld_pipe = {1'b0, 1'b0};
        kv_pipe = {3'd0, 3'd0};
        s2_hist.delete();
        for (int i = 0; i < DB; i++) s2_hist.push_back(1'b0);
    endtask

    // One rising edge of the reference behaviour, using inputs held at that edge
    task automatic model_step();
        bit         s2l;
        logic [2:0] s2k;
        bit         all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        s2l = ld_pipe.pop_front();
        ld_pipe.push_back(key_load);
        s2k = kv_pipe.pop_front();
        kv_pipe.push_back(keyin);
        if (m_press) begin
            m_sel = s2k;
            exp_q.push_back(m_sel);
        end
        if (!m_running) begin
            if (run) begin
                m_running = 1'b1;
                m_dir     = 1;
                m_period  = 0;
            end
        end else if (!run) begin
            m_running = 1'b0;
            m_period  = 0;
        end else if (m_press) begin
            m_period = 0;
        end else begin
            m_period++;
            if (m_period == TD) begin
                m_period = 0;
                if (pingpong && m_dir == 1 && m_sel == 3'd7) begin
                    m_dir = -1;
                    m_sel = 3'd6;
                end else if (pingpong && m_dir == -1 && m_sel == 3'd0) begin
                    m_dir = 1;
                    m_sel = 3'd1;
                end else begin
                    m_sel = 3'((int'(m_sel) + m_dir + 8) % 8);
                end
                exp_q.push_back(m_sel);
            end
        end
        s2_hist.push_back(s2l);
        if (s2_hist.size() > DB) void'(s2_hist.pop_front());
        all_diff = 1'b1;
        foreach (s2_hist[i]) if (s2_hist[i] == m_db) all_diff = 1'b0;
        m_press = 1'b0;
        if (all_diff) begin
            m_db    = ~m_db;
            m_press = m_db;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes step
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (sel !== m_sel) begin
                n_bad++;
                $display("FAIL sel_track: got %0h expected %0h", sel, m_sel);
            end
            n_cmp++;
            if (led !== ~(8'd1 << m_sel)) begin
                n_bad++;
                $display("FAIL led_track: got %0h expected %0h", led, ~(8'd1 << m_sel));
            end
            n_cmp++;
            if (step === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_step: got step=1 expected step=0 sel=%0h", sel);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if (sel !== e || led !== ~(8'd1 << e)) begin
                        n_bad++;
                        $display("FAIL step_value: got sel=%0h led=%0h expected sel=%0h", sel, led, e);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL missed_step: got step=%b expected step=1 sel=%0h", step, exp_q[0]);
                exp_q.delete();
            end
        end
    end

    task automatic wait_for(input string name, input logic [2:0] s, input bit need_run);
        int i;
        for (i = 0; i < 100; i++) begin
            if (m_sel == s && (!need_run || m_running)) break;
            cycle();
        end
        check({name, "_reached"}, i < 100, 1);
    endtask

    initial begin
        int lat;
        int hold_left;
        rst = 1'b1; keyin = 3'd0; key_load = 1'b0; run = 1'b0; pingpong = 1'b0;
        model_reset();
        cycle();
        mon_en = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        check("reset_sel", sel, 0);
        check("reset_led", led, 8'hFE);
        check("reset_step", step, 0);
        repeat (6) cycle();
        check("idle_hold_led", led, 8'hFE);

        // Manual load with latency measurement
        keyin = 3'd5; key_load = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (step === 1'b1) begin lat = i; break; end
        end
        check("load_latency", lat, DB + 3);
        check("load_sel", sel, 5);
        check("load_led", led, 8'hDF);
        repeat (10 - lat) cycle();
        key_load = 1'b0;
        repeat (10) cycle();

        // Short glitch must be ignored
        keyin = 3'd1; key_load = 1'b1;
        repeat (3) cycle();
        key_load = 1'b0;
        repeat (12) cycle();
        check("glitch_sel", sel, 5);

        // Load 6, then auto wrap
        keyin = 3'd6; key_load = 1'b1;
        repeat (10) cycle();
        key_load = 1'b0;
        repeat (6) cycle();
        check("preload_sel", sel, 6);
        run = 1'b1;
        repeat (TD + 1) cycle();
        check("wrap_first", sel, 7);
        repeat (TD) cycle();
        check("wrap_zero", led, 8'hFE);
        repeat (TD) cycle();
        check("wrap_one", led, 8'hFD);

        // Ping-pong sweep across both ends
        pingpong = 1'b1;
        repeat (18 * TD) cycle();

        // Collision: press strobe lands on the terminal tick count
        pingpong = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_running && m_period == 1) break;
            cycle();
        end
        keyin = 3'd2; key_load = 1'b1;
        repeat (DB + 3) cycle();
        check("collision_sel", sel, 2);
        repeat (3) cycle();
        key_load = 1'b0;
        repeat (12) cycle();

        // Stop at 3, then resume upward
        wait_for("stop3", 3'd3, 1'b1);
        run = 1'b0;
        repeat (3 * TD) cycle();
        check("stop_hold", sel, 3);
        run = 1'b1;
        repeat (TD + 1) cycle();
        check("resume_up", sel, 4);

        // Reset mid-run
        repeat (2) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0; run = 1'b0;
        check("midrun_reset_led", led, 8'hFE);
        repeat (8) cycle();

        // Randomized traffic
        hold_left = 1;
        for (int i = 0; i < 4000; i++) begin
            keyin = 3'($urandom_range(0, 7));
            hold_left--;
            if (hold_left <= 0) begin
                key_load  = ~key_load;
                hold_left = $urandom_range(1, 10);
            end
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) pingpong = ~pingpong;
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0; run = 1'b0; key_load = 1'b0;
        repeat (15) cycle();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
